// File: rtl/engine_rpm_gen_if.sv
// ----------------------------------------------------------------------------
// engine_rpm_gen_if
//   Groups the engine controls and the engine state outputs of engine_rpm_gen.
//
//   Signals:
//     engine_on      controls -> engine  level, engine running
//     throttle       controls -> engine  level, accelerator pressed
//     shift_up       controls -> engine  single-cycle pulse
//     shift_down     controls -> engine  single-cycle pulse
//     rpm[13:0]      engine -> consumers current engine rpm, unsigned
//     gear[2:0]      engine -> consumers 0 = neutral, 1..5
//     limiter_active engine -> consumers high during rev-limiter fuel cut
//     shifting       engine -> consumers high during a gear change
//     tick           engine -> consumers one-cycle pulse on each rpm update
//
//   Modports: master drives the controls (input logic / bench),
//             slave is the engine model itself.
// ----------------------------------------------------------------------------
interface engine_rpm_gen_if;
    logic        engine_on;
    logic        throttle;
    logic        shift_up;
    logic        shift_down;
    logic [13:0] rpm;
    logic [2:0]  gear;
    logic        limiter_active;
    logic        shifting;
    logic        tick;

    modport master (
        output engine_on, throttle, shift_up, shift_down,
        input  rpm, gear, limiter_active, shifting, tick
    );

    modport slave (
        input  engine_on, throttle, shift_up, shift_down,
        output rpm, gear, limiter_active, shifting, tick
    );
endinterface

// File: rtl/engine_rpm_gen.sv
// ----------------------------------------------------------------------------
// engine_rpm_gen
//   Engine speed model for the player car. Once per internal tick it applies
//   idle, throttle acceleration, release decay, the rev-limiter fuel cut and
//   holds throttle off during gear changes. Shift requests and engine-off are
//   handled in the cycle they arrive.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    engine_rpm_gen_if.slave (controls in, rpm/gear/status out)
//
//   Optional feature (macro LAUNCH_CONTROL_EN):
//     defined   - in neutral with throttle held, rpm is clamped at LAUNCH_RPM
//                 and the limiter is never reached in neutral.
//     undefined - neutral revs like any other gear.
// ----------------------------------------------------------------------------
module engine_rpm_gen #(
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned IDLE_RPM    = 900,
    parameter int unsigned LIMIT_RPM   = 10800,
    parameter int unsigned CUT_DROP    = 400,
    parameter int unsigned CUT_TICKS   = 20,
    parameter int unsigned SHIFT_TICKS = 150,
    parameter int unsigned ACCEL_BASE  = 32,
    parameter int unsigned DECAY_STEP  = 6,
    parameter int unsigned LAUNCH_RPM  = 6000
) (
    input  logic           clk,
    input  logic           rst_n,
    engine_rpm_gen_if.slave bus
);

    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_MAX = (CUT_TICKS > SHIFT_TICKS) ? CUT_TICKS : SHIFT_TICKS;
    localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CUT   = 2'd2;
    localparam logic [1:0] ST_SHIFT = 2'd3;

    localparam logic [2:0]  TOP_GEAR = 3'd5;
    localparam logic [13:0] RPM_MAX  = 14'h3FFF;
    localparam logic [13:0] IDLE14   = 14'(IDLE_RPM);
    localparam logic [13:0] LIMIT14  = 14'(LIMIT_RPM);
    localparam logic [13:0] DROP14   = 14'(CUT_DROP);
    localparam logic [13:0] ACCEL14  = 14'(ACCEL_BASE);
    localparam logic [13:0] DECAY14  = 14'(DECAY_STEP);
    localparam logic [13:0] LAUNCH14 = 14'(LAUNCH_RPM);

    logic [1:0]    state_q, state_d;
    logic [13:0]   rpm_q, rpm_d;
    logic [2:0]    gear_q, gear_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [PW-1:0] presc_q, presc_d;

    logic        tick_w;
    logic        shift_ok;
    logic        launch_clamp;
    logic [13:0] accel_step;
    logic [14:0] accel_sum;
    logic [13:0] accel_sat;
    logic [13:0] decay_val;
    logic [13:0] upshift_raw;
    logic [13:0] upshift_val;
    logic [14:0] downshift_raw;
    logic [13:0] downshift_val;
    logic [13:0] launch_val;

    assign tick_w = bus.engine_on && (presc_q == PW'(TICK_DIV - 1));

    // Exactly one of the two pulses, into a gear that exists, from RUN or CUT.
    assign shift_ok = ((state_q == ST_RUN) || (state_q == ST_CUT))
                   && (bus.shift_up ^ bus.shift_down)
                   && (bus.shift_up ? (gear_q != TOP_GEAR) : (gear_q != 3'd0));

    // Neutral uses the full base step; each gear halves it again.
    assign accel_step = (gear_q == 3'd0) ? ACCEL14 : (ACCEL14 >> gear_q);
    assign accel_sum  = 15'(rpm_q) + 15'(accel_step);
    assign accel_sat  = accel_sum[14] ? RPM_MAX : accel_sum[13:0];

    // Compare before subtracting so the floor also protects against underflow.
    assign decay_val  = (rpm_q < IDLE14 + DECAY14) ? IDLE14 : rpm_q - DECAY14;

    assign upshift_raw   = rpm_q - (rpm_q >> 2);
    assign upshift_val   = (upshift_raw < IDLE14) ? IDLE14 : upshift_raw;
    assign downshift_raw = 15'(rpm_q) + 15'(rpm_q >> 2);
    assign downshift_val = (downshift_raw > 15'(LIMIT14 - 14'd1)) ? (LIMIT14 - 14'd1)
                                                                  : downshift_raw[13:0];

    // The clamp value is always formed; only the launch build ever selects it.
    assign launch_val = (accel_sat > LAUNCH14) ? LAUNCH14 : accel_sat;
`ifdef LAUNCH_CONTROL_EN
    assign launch_clamp = (gear_q == 3'd0);
`else
    assign launch_clamp = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        rpm_d   = rpm_q;
        gear_d  = gear_q;
        hold_d  = hold_q;
        presc_d = tick_w ? '0 : presc_q + 1'b1;

        if (!bus.engine_on) begin
            state_d = ST_OFF;
            rpm_d   = '0;
            gear_d  = '0;
            hold_d  = '0;
            presc_d = '0;
        end else if (shift_ok) begin
            // A shift takes effect immediately and pre-empts a coincident tick.
            if (bus.shift_up) begin
                gear_d = gear_q + 3'd1;
                if (gear_q != 3'd0) rpm_d = upshift_val;
            end else begin
                gear_d = gear_q - 3'd1;
                if (gear_q != 3'd1) rpm_d = downshift_val;
            end
            state_d = ST_SHIFT;
            hold_d  = HW'(SHIFT_TICKS);
        end else if (tick_w) begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_RUN;
                    rpm_d   = IDLE14;
                    gear_d  = '0;
                end
                ST_RUN: begin
                    if (!bus.throttle) begin
                        rpm_d = decay_val;
                    end else if (launch_clamp) begin
                        rpm_d = launch_val;
                    end else if (accel_sat >= LIMIT14) begin
                        rpm_d   = accel_sat - DROP14;
                        state_d = ST_CUT;
                        hold_d  = HW'(CUT_TICKS);
                    end else begin
                        rpm_d = accel_sat;
                    end
                end
                default: begin
                    // CUT and SHIFT: throttle ignored, count down the hold.
                    rpm_d  = decay_val;
                    hold_d = hold_q - 1'b1;
                    if (hold_q <= HW'(1)) state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the values from before this edge.
        if (!rst_n) begin
            state_q <= ST_OFF;
            rpm_q   <= '0;
            gear_q  <= '0;
            hold_q  <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            rpm_q   <= rpm_d;
            gear_q  <= gear_d;
            hold_q  <= hold_d;
            presc_q <= presc_d;
        end
    end

    assign bus.rpm            = rpm_q;
    assign bus.gear           = gear_q;
    assign bus.limiter_active = (state_q == ST_CUT);
    assign bus.shifting       = (state_q == ST_SHIFT);
    assign bus.tick           = tick_w;

endmodule

// File: tb/tb_engine_rpm_gen.sv
// ----------------------------------------------------------------------------
// tb_engine_rpm_gen
//   Scenario bench for engine_rpm_gen with TICK_DIV=4. A behavioural model of
//   the engine (plain integer arithmetic on rpm, gear and ticks remaining) is
//   advanced alongside the design every clock and compared with its outputs,
//   plus directed spot values for idle, acceleration, limiter and shifts.
//   Honours LAUNCH_CONTROL_EN when the design is built with it.
// ----------------------------------------------------------------------------
module tb_engine_rpm_gen;

    localparam int TD     = 4;
    localparam int IDLE   = 900;
    localparam int LIMIT  = 10800;
    localparam int DROP   = 400;
    localparam int CUTT   = 20;
    localparam int SHT    = 150;
    localparam int ACC    = 32;
    localparam int DEC    = 6;
    localparam int LAUNCH = 6000;
`ifdef LAUNCH_CONTROL_EN
    localparam bit LAUNCH_ON = 1'b1;
`else
    localparam bit LAUNCH_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    engine_rpm_gen_if bus();

    engine_rpm_gen #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef enum int {M_OFF, M_RUN, M_CUT, M_SHIFT} mstate_e;
    mstate_e m_state;
    int m_rpm, m_gear, m_hold, m_phase;

    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

    task automatic model_reset();
        m_state = M_OFF; m_rpm = 0; m_gear = 0; m_hold = 0; m_phase = 0;
    endtask

    // Applies one clock of engine rules using the inputs currently driven.
    task automatic model_update();
        bit t;
        int r;
        t = bus.engine_on && (m_phase == TD - 1);
        if (!bus.engine_on) begin
            model_reset();
            return;
        end
        m_phase = t ? 0 : m_phase + 1;
        r = m_rpm;
        if ((m_state == M_RUN || m_state == M_CUT) && (bus.shift_up != bus.shift_down)
            && (bus.shift_up ? (m_gear < 5) : (m_gear > 0))) begin
            if (bus.shift_up) begin
                if (m_gear >= 1) r = imax(IDLE, r - r / 4);
                m_gear = m_gear + 1;
            end else begin
                m_gear = m_gear - 1;
                if (m_gear >= 1) r = imin(LIMIT - 1, r + r / 4);
            end
            m_rpm = r; m_state = M_SHIFT; m_hold = SHT;
        end else if (t) begin
            case (m_state)
                M_OFF: begin m_state = M_RUN; m_rpm = IDLE; m_gear = 0; end
                M_RUN: begin
                    if (!bus.throttle) m_rpm = imax(IDLE, r - DEC);
                    else begin
                        r = imin(16383, r + ((m_gear == 0) ? ACC : (ACC >> m_gear)));
                        if (LAUNCH_ON && m_gear == 0) m_rpm = imin(r, LAUNCH);
                        else if (r >= LIMIT) begin
                            m_rpm = r - DROP; m_state = M_CUT; m_hold = CUTT;
                        end else m_rpm = r;
                    end
                end
                default: begin
                    m_rpm  = imax(IDLE, r - DEC);
                    m_hold = m_hold - 1;
                    if (m_hold == 0) m_state = M_RUN;
                end
            endcase
        end
    endtask

    function automatic logic [19:0] exp_out();
        logic [31:0] r, g;
        r = m_rpm; g = m_gear;
        return {r[13:0], g[2:0], m_state == M_CUT, m_state == M_SHIFT,
                bus.engine_on && (m_phase == TD - 1)};
    endfunction

    function automatic logic [19:0] dut_out();
        return {bus.rpm, bus.gear, bus.limiter_active, bus.shifting, bus.tick};
    endfunction

    // One clock: model advances on the inputs of this cycle, outputs then
    // sampled 1 time unit after the rising edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit up, input bit down);
        bus.shift_up = up; bus.shift_down = down;
        step();
        bus.shift_up = 1'b0; bus.shift_down = 1'b0;
    endtask

    task automatic run_while_shifting(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.shifting === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bus.engine_on = 1'b1; bus.throttle = 1'b0;
        bus.shift_up = 1'b0; bus.shift_down = 1'b0;
        model_reset();
        #3;
        checks++;
        if (dut_out() !== 20'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", dut_out(), 20'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 204; i++) begin
            step();
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++; $display("FAIL idle cyc%0d: got %h expected %h", i, dut_out(), exp_out());
            end
            if (i == 3) begin
                checks++;
                if (bus.rpm !== 14'd900) begin
                    errors++; $display("FAIL first_tick_rpm: got %0d expected 900", bus.rpm);
                end
            end
        end
        checks++;
        if (bus.rpm !== 14'd900 || bus.gear !== 3'd0) begin
            errors++; $display("FAIL idle_hold: got rpm %0d gear %0d expected 900 0", bus.rpm, bus.gear);
        end
    endtask

    task automatic test_accel_decay();
        bus.throttle = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++; $display("FAIL accel cyc%0d: got %h expected %h", i, dut_out(), exp_out());
            end
        end
        checks++;
        if (bus.rpm !== 14'd1220) begin
            errors++; $display("FAIL accel_10_ticks: got %0d expected 1220", bus.rpm);
        end
        bus.throttle = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++; $display("FAIL decay cyc%0d: got %h expected %h", i, dut_out(), exp_out());
            end
        end
        checks++;
        if (bus.rpm !== 14'd1160) begin
            errors++; $display("FAIL decay_10_ticks: got %0d expected 1160", bus.rpm);
        end
    endtask

    task automatic test_limiter();
        bit saw_cut = 1'b0, ended = 1'b0;
        int prev, end_rpm, cut_ticks = 0, post = 0;
        bus.throttle = 1'b1;
        for (int i = 0; i < 4000 && !(ended && post >= 40); i++) begin
            prev = int'(bus.rpm);
            step();
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++; $display("FAIL limiter cyc%0d: got %h expected %h", i, dut_out(), exp_out());
            end
            if (bus.limiter_active === 1'b1 && !saw_cut) begin
                saw_cut = 1'b1;
                checks++;
                if (int'(bus.rpm) != prev + ACC - DROP) begin
                    errors++; $display("FAIL cut_drop: got %0d expected %0d", bus.rpm, prev + ACC - DROP);
                end
            end
            if (saw_cut && bus.limiter_active === 1'b1 && bus.tick === 1'b1) cut_ticks++;
            if (saw_cut && !ended && bus.limiter_active === 1'b0) begin
                ended = 1'b1; end_rpm = int'(bus.rpm);
            end
            if (ended) post++;
            if (LAUNCH_ON && i >= 1400) break;
        end
        checks++;
        if (LAUNCH_ON) begin
            if (saw_cut || bus.rpm !== 14'd6000) begin
                errors++; $display("FAIL launch_hold: got rpm %0d cut %0d expected 6000 0", bus.rpm, saw_cut);
            end
        end else begin
            if (!ended) begin
                errors++; $display("FAIL limiter_reached: got cut %0d ended %0d expected 1 1", saw_cut, ended);
            end else begin
                checks++;
                if (cut_ticks != CUTT) begin
                    errors++; $display("FAIL cut_length: got %0d ticks expected %0d", cut_ticks, CUTT);
                end
                if (int'(bus.rpm) <= end_rpm) begin
                    errors++; $display("FAIL climb_after_cut: got %0d expected above %0d", bus.rpm, end_rpm);
                end
            end
        end
        bus.throttle = 1'b0;
    endtask

    task automatic test_shift();
        bit ok;
        int r, a;
        bus.engine_on = 1'b0; step();
        bus.engine_on = 1'b1;
        repeat (4) step();
        pulse(1'b1, 1'b0); run_while_shifting(ok);
        pulse(1'b1, 1'b0); run_while_shifting(ok);
        checks++;
        if (!ok || bus.gear !== 3'd2 || dut_out() !== exp_out()) begin
            errors++; $display("FAIL reach_gear2: got gear %0d out %h expected 2 %h", bus.gear, dut_out(), exp_out());
        end
        bus.throttle = 1'b1;
        for (int i = 0; i < 6000 && bus.rpm < 14'd8000; i++) begin
            step();
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++; $display("FAIL gear2_climb cyc%0d: got %h expected %h", i, dut_out(), exp_out());
            end
        end
        r = int'(bus.rpm);
        pulse(1'b1, 1'b0);
        checks++;
        if (r < 8000 || bus.gear !== 3'd3 || int'(bus.rpm) != r - r / 4 || bus.shifting !== 1'b1) begin
            errors++; $display("FAIL upshift_2_3: got gear %0d rpm %0d shifting %0d expected 3 %0d 1",
                               bus.gear, bus.rpm, bus.shifting, r - r / 4);
        end
        run_while_shifting(ok);
        checks++;
        if (!ok || int'(bus.rpm) != r - r / 4 - SHT * DEC) begin
            errors++; $display("FAIL shift_window: got %0d expected %0d", bus.rpm, r - r / 4 - SHT * DEC);
        end
        a = int'(bus.rpm);
        repeat (4) step();
        checks++;
        if (int'(bus.rpm) != a + 4 || dut_out() !== exp_out()) begin
            errors++; $display("FAIL gear3_step: got %0d expected %0d", bus.rpm, a + 4);
        end
    endtask

    task automatic test_ignored_shifts();
        bit ok;
        pulse(1'b1, 1'b0); run_while_shifting(ok);
        pulse(1'b1, 1'b0); run_while_shifting(ok);
        checks++;
        if (!ok || bus.gear !== 3'd5) begin
            errors++; $display("FAIL reach_gear5: got %0d expected 5", bus.gear);
        end
        for (int k = 0; k < 2; k++) begin
            pulse(1'b1, k == 1);
            checks++;
            if (bus.gear !== 3'd5 || bus.shifting !== 1'b0 || dut_out() !== exp_out()) begin
                errors++; $display("FAIL gear5_ignore%0d: got %h expected %h", k, dut_out(), exp_out());
            end
        end
        bus.throttle = 1'b0;
        bus.engine_on = 1'b0; step();
        bus.engine_on = 1'b1;
        repeat (4) step();
        for (int k = 0; k < 2; k++) begin
            pulse(k == 1, 1'b1);
            checks++;
            if (bus.gear !== 3'd0 || bus.shifting !== 1'b0 || bus.rpm !== 14'd900) begin
                errors++; $display("FAIL neutral_ignore%0d: got gear %0d rpm %0d shifting %0d expected 0 900 0",
                                   k, bus.gear, bus.rpm, bus.shifting);
            end
        end
    endtask

    task automatic test_off_mid_shift();
        pulse(1'b1, 1'b0);
        repeat (10) step();
        checks++;
        if (bus.shifting !== 1'b1 || dut_out() !== exp_out()) begin
            errors++; $display("FAIL in_shift: got %h expected %h", dut_out(), exp_out());
        end
        bus.engine_on = 1'b0;
        step();
        checks++;
        if (dut_out() !== 20'd0) begin
            errors++; $display("FAIL off_mid_shift: got %h expected %h", dut_out(), 20'd0);
        end
        bus.engine_on = 1'b1;
    endtask

    task automatic test_async_reset_mid_cut();
        bit ok;
        repeat (4) step();
        pulse(1'b1, 1'b0); run_while_shifting(ok);
        bus.throttle = 1'b1;
        for (int i = 0; i < 4000 && bus.limiter_active !== 1'b1; i++) begin
            step();
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++; $display("FAIL gear1_climb cyc%0d: got %h expected %h", i, dut_out(), exp_out());
            end
        end
        repeat (8) step();
        checks++;
        if (bus.limiter_active !== 1'b1 || dut_out() !== exp_out()) begin
            errors++; $display("FAIL gear1_cut: got %h expected %h", dut_out(), exp_out());
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_out() !== 20'd0) begin
            errors++; $display("FAIL async_reset: got %h expected %h", dut_out(), 20'd0);
        end
        model_reset();
        bus.throttle = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        bus.throttle = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.engine_on  = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 19) == 0) bus.throttle = ~bus.throttle;
            bus.shift_up   = ($urandom_range(0, 49) == 0);
            bus.shift_down = ($urandom_range(0, 49) == 0);
            step();
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++; $display("FAIL random cyc%0d: got %h expected %h", i, dut_out(), exp_out());
            end
        end
        bus.shift_up = 1'b0; bus.shift_down = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_accel_decay();
        test_limiter();
        test_shift();
        test_ignored_shifts();
        test_off_mid_shift();
        test_async_reset_mid_cut();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
